// File: rtl/rd_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : rd_frame_buf
// Purpose  : Single-clock true dual-port line buffer RAM for the read-side
//            frame buffer. Port A is normally filled by DDR read-burst beats,
//            and port B is drained sequentially to produce video/PCIe words.
//            Both ports can read and write. Reads are synchronous and
//            read-first. If both ports write the same address, port A wins.
// Ports    : clk                    - single clock for both ports
//            rst                    - async active-high reset of the output
//                                     registers only (the array is not reset)
//            a_addr / b_addr        - port address, ADDR_WIDTH bits
//            a_wr_data / b_wr_data  - port write data, DATA_WIDTH bits
//            a_wr_en / b_wr_en      - port write strobe
//            a_rd_data / b_rd_data  - registered read data, DATA_WIDTH bits
// Config   : RD_FRAME_BUF_OUTREG_EN - when defined, a second output register
//                                     stage is added and read latency is 2
// Revision : 1.0 - initial release
// ============================================================================
module rd_frame_buf #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  input  logic                  a_wr_en,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  input  logic                  b_wr_en,
  output logic [DATA_WIDTH-1:0] b_rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] a_rd_q;
  logic [DATA_WIDTH-1:0] b_rd_q;
  logic                  b_wr_allow;

  // A port B write to the address that port A writes in the same cycle is
  // dropped, so port A's data is the one stored.
  assign b_wr_allow = b_wr_en && !(a_wr_en && (a_addr == b_addr));

  // Storage has no reset. Writes still happen while rst is high.
  always_ff @(posedge clk) begin
    if (a_wr_en) begin
      mem_q[a_addr] <= a_wr_data;
    end
    if (b_wr_allow) begin
      mem_q[b_addr] <= b_wr_data;
    end
  end

  // The read samples the array before this edge's writes land. This gives
  // read-first behaviour on both the same port and the other port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rd_q <= '0;
      b_rd_q <= '0;
    end else begin
      a_rd_q <= mem_q[a_addr];
      b_rd_q <= mem_q[b_addr];
    end
  end

`ifdef RD_FRAME_BUF_OUTREG_EN
  logic [DATA_WIDTH-1:0] a_rd2_q;
  logic [DATA_WIDTH-1:0] b_rd2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rd2_q <= '0;
      b_rd2_q <= '0;
    end else begin
      a_rd2_q <= a_rd_q;
      b_rd2_q <= b_rd_q;
    end
  end

  assign a_rd_data = a_rd2_q;
  assign b_rd_data = b_rd2_q;
`else
  assign a_rd_data = a_rd_q;
  assign b_rd_data = b_rd_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rd_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_frame_buf
// Purpose  : Directed self-checking bench for rd_frame_buf.
//            Covers reset, sequential burst, wrap, read-first collisions,
//            dual-write collision and asynchronous reset mid-stream.
//            Honours RD_FRAME_BUF_OUTREG_EN for the read latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rd_frame_buf;

`ifdef RD_FRAME_BUF_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam int DW = 128;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wr_data, b_wr_data;
  logic          a_wr_en, b_wr_en;
  logic [DW-1:0] a_rd_data, b_rd_data;

  int n_vec = 0;
  int n_err = 0;

  rd_frame_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_addr    (a_addr),
    .a_wr_data (a_wr_data),
    .a_wr_en   (a_wr_en),
    .a_rd_data (a_rd_data),
    .b_addr    (b_addr),
    .b_wr_data (b_wr_data),
    .b_wr_en   (b_wr_en),
    .b_rd_data (b_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one active edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    logic [15:0] a16;
    a16 = 16'(a);
    return {8{a16}};
  endfunction

  localparam logic [DW-1:0] VAL_A5 = {16{8'hA5}};
  localparam logic [DW-1:0] VAL_X  = {4{32'h1111_2222}};
  localparam logic [DW-1:0] VAL_Y  = {4{32'h3333_4444}};
  localparam logic [DW-1:0] VAL_HI = {4{32'hDEAD_BEEF}};
  localparam logic [DW-1:0] VAL_LO = {4{32'h0BAD_F00D}};
  localparam logic [DW-1:0] VAL_Z  = {4{32'hCAFE_0020}};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_addr = '0; b_addr = '0; a_wr_data = '0; b_wr_data = '0;
    a_wr_en = 1'b0; b_wr_en = 1'b0;

    // Reset held: outputs stay zero whatever the addresses are.
    for (int i = 0; i < 4; i++) begin
      a_addr = AW'($urandom_range(0, 1023));
      b_addr = AW'($urandom_range(0, 1023));
      step();
    end
    check("rst_a", a_rd_data, '0);
    check("rst_b", b_rd_data, '0);

    // Release, write A5 pattern to address 5, then read it back on B.
    #3 rst = 1'b0;
    step();
    a_addr = 10'd5; a_wr_data = VAL_A5; a_wr_en = 1'b1;
    step();
    a_wr_en = 1'b0; b_addr = 10'd5;
    for (int i = 0; i < LAT; i++) step();
    check("first_rd_b", b_rd_data, VAL_A5);

    // Sequential burst: A fills every address.
    for (int i = 0; i < 1024; i++) begin
      a_addr = AW'(i); a_wr_data = pat(i); a_wr_en = 1'b1;
      step();
    end
    a_wr_en = 1'b0;
    // B reads one new address per cycle. Data for address i shows after edge i+LAT-1.
    for (int i = 0; i < 1024 + LAT - 1; i++) begin
      b_addr = AW'(i);
      step();
      if (i >= LAT - 1) check("burst_b", b_rd_data, pat(i - LAT + 1));
    end

    // Wrap: 1023 then 0 with distinct values.
    a_addr = 10'd1023; a_wr_data = VAL_HI; a_wr_en = 1'b1; step();
    a_addr = 10'd0;    a_wr_data = VAL_LO; step();
    a_wr_en = 1'b0;
    b_addr = 10'd1023; step();
    b_addr = 10'd0;
    if (LAT == 1) check("wrap_1023", b_rd_data, VAL_HI);
    step();
    if (LAT == 1) check("wrap_0", b_rd_data, VAL_LO);
    else          check("wrap_1023", b_rd_data, VAL_HI);
    step();
    if (LAT == 2) check("wrap_0", b_rd_data, VAL_LO);

    // Read-first, A writes while both ports read address 7.
    a_addr = 10'd7; a_wr_data = VAL_X; a_wr_en = 1'b1; step();
    a_wr_data = VAL_Y; b_addr = 10'd7; step();
    a_wr_en = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    check("rf_b_old", b_rd_data, VAL_X);
    check("rf_a_old", a_rd_data, VAL_X);
    step();
    check("rf_b_new", b_rd_data, VAL_Y);
    check("rf_a_new", a_rd_data, VAL_Y);

    // Read-first, swapped: B writes X back to 7 while A reads it.
    b_wr_data = VAL_X; b_wr_en = 1'b1; step();
    b_wr_en = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    check("rf_swap_a_old", a_rd_data, VAL_Y);
    step();
    check("rf_swap_a_new", a_rd_data, VAL_X);

    // Dual-write collision at address 9: port A wins.
    a_addr = 10'd9; b_addr = 10'd9;
    a_wr_data = 128'd1; b_wr_data = 128'd2;
    a_wr_en = 1'b1; b_wr_en = 1'b1; step();
    a_wr_en = 1'b0; b_wr_en = 1'b0;
    for (int i = 0; i < LAT; i++) step();
    check("dual_wr_a", a_rd_data, 128'd1);
    check("dual_wr_b", b_rd_data, 128'd1);

    // Async reset mid-stream during a B read burst.
    for (int i = 100; i < 104; i++) begin
      b_addr = AW'(i); step();
    end
    check("pre_rst_b", b_rd_data, pat(104 - LAT));
    #2 rst = 1'b1;
    #1;
    check("async_rst_a", a_rd_data, '0);
    check("async_rst_b", b_rd_data, '0);
    // A write while reset is high still lands in the array.
    a_addr = 10'd20; a_wr_data = VAL_Z; a_wr_en = 1'b1;
    step();
    a_wr_en = 1'b0;
    check("rst_hold_b", b_rd_data, '0);
    #2 rst = 1'b0;
    a_addr = 10'd20; b_addr = 10'd200;
    for (int i = 0; i < LAT; i++) step();
    check("post_rst_wr", a_rd_data, VAL_Z);
    check("post_rst_keep", b_rd_data, pat(200));
    // Address held: output holds its value.
    step();
    check("hold_b", b_rd_data, pat(200));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rd_frame_buf.md
# rd_frame_buf

Single-clock true dual-port line buffer RAM, 1024 × 128 bit by default, sitting inside the read-side frame buffer. Port A takes 128-bit DDR read-burst beats at an incrementing write address. Port B is read back sequentially to produce 128-bit video/PCIe output words. Both ports can read and write. Read data is synchronous, with a fixed latency.

## Interface
Parameters:
- `DATA_WIDTH`, default 128: word width of both ports.
- `ADDR_WIDTH`, default 10: address width; depth = 2**ADDR_WIDTH (1024).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: single clock for both ports.
- `rst`  in  1: asynchronous, active-high reset of the output data registers.
- `a_addr`  in  ADDR_WIDTH: port A address.
- `a_wr_data`  in  DATA_WIDTH: port A write data.
- `a_wr_en`  in  1: port A write strobe.
- `a_rd_data`  out  DATA_WIDTH: port A read data.
- `b_addr`  in  ADDR_WIDTH: port B address.
- `b_wr_data`  in  DATA_WIDTH: port B write data.
- `b_wr_en`  in  1: port B write strobe.
- `b_rd_data`  out  DATA_WIDTH: port B read data.

## Operation
- Storage is a 2**ADDR_WIDTH × DATA_WIDTH array.
- Reset does not clear the array. Contents after power-up are undefined.
- Writes: on a `clk` edge with `x_wr_en`=1, `mem[x_addr]` <= `x_wr_data`.
- Reads: every cycle, each port reads `mem[x_addr]` into its output register. Reads occur regardless of wr_en; there is no read enable.
- Read-during-write, same port: read-first. `x_rd_data` returns the word stored before the write.
- Cross-port collision, A writes while B reads the same address: B returns the old data (read-first). The same rule applies with the ports swapped.
- Both ports write the same address in the same cycle: port A's data is stored and port B's write is dropped.
- Addresses are plain binary. The caller handles wrap (the 10-bit counter rolling over 1023→0). The RAM does no bounds logic.
- Full/empty state is not tracked here. Fill level is computed by the enclosing buffer from its pointers.

## Timing
- Reset values: `a_rd_data` = 0 and `b_rd_data` = 0 while `rst`=1.
- Reset assertion clears the outputs immediately (asynchronous). Deassertion takes effect at the next `clk` edge.
- Reset mid-operation: outputs go to 0 at once. Array contents and any write in the same cycle are unaffected; writes still occur while `rst`=1.
- Read latency is 1 cycle without the configuration macro. Address presented before edge N gives data valid after edge N.
- Write-to-read latency: data written at edge N can be read at edge N+1, appearing on the output after N+1.
- Throughput: one write and one read per port per cycle, with no stalls.
- Output registers hold their value when the address is held.

## Configuration
- `RD_FRAME_BUF_OUTREG_EN`: when defined, adds a second output register stage on both ports.
  - Read latency becomes 2 cycles.
  - The second stage also resets asynchronously to 0.
  - Collision rules are unchanged; data is delayed one more cycle.
- When not defined, read latency is 1 cycle as specified above.

## Test plan
- Reset: hold `rst`=1, drive random addresses -> both `rd_data` = 0. Release; read address 5 after writing 128'hA5..A5 -> data appears 1 cycle later (2 with the macro).
- Sequential burst: A writes addr 0..1023 with data = {8{addr16}}, then B reads 0..1023 -> every word matches, one word per cycle at fixed latency.
- Wrap: A writes addr 1023 then 0 with distinct values. B reads 1023, 0 -> correct distinct values, no aliasing.
- Read-first: address 7 holds X; A writes Y to 7 while B reads 7 -> B returns X. The next B read of 7 returns Y. A's own `a_rd_data` in the write cycle is X.
- Dual-write collision: A writes 1 and B writes 2 to address 9 in the same cycle -> a later read returns 1.
- Async reset mid-stream: assert `rst` between edges during a burst -> outputs are 0 before the next edge. After release, previously written words are still intact.
